// File: rtl/simd_mac_accumulator.sv
// SIMD multiply-accumulate stage: sums int8/int4/int2 product lanes per group into
// unsigned saturating per-lane accumulators and hands one result per group downstream.
module simd_mac_accumulator #(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [1:0]           in_mode,
    input  logic [15:0]          in_result,
    input  logic [7:0]           in_int4_0,
    input  logic [7:0]           in_int4_1,
    input  logic [3:0]           in_int2_0,
    input  logic [3:0]           in_int2_1,
    input  logic [3:0]           in_int2_2,
    input  logic [3:0]           in_int2_3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*ACC_W-1:0]   out_acc,
    output logic [1:0]           out_mode,
    output logic [3:0]           out_ovf,
    output logic [CNT_W-1:0]     out_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc [4];
    logic [3:0]         ovf;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   count;

    logic               accept;
    logic               handover;
    logic [1:0]         eff_mode;
    logic [ACC_W-1:0]   prod     [4];
    logic [ACC_W-1:0]   base     [4];
    logic [ACC_W:0]     sum      [4];
    logic [ACC_W-1:0]   acc_nxt  [4];
    logic [3:0]         ovf_nxt;
    logic [CNT_W-1:0]   count_nxt;

    assign accept   = in_valid && in_ready;
    assign handover = out_valid && out_ready;

    // The first beat of a group selects the mode; later beats reuse the latched one.
    always_comb begin
        eff_mode = (state == S_IDLE) ? in_mode : mode_q;
        for (int unsigned k = 0; k < 4; k++) begin
            prod[k] = '0;
        end
        case (eff_mode)
            2'b01: begin
                prod[0] = ACC_W'(in_int4_0);
                prod[1] = ACC_W'(in_int4_1);
            end
            2'b10: begin
                prod[0] = ACC_W'(in_int2_0);
                prod[1] = ACC_W'(in_int2_1);
                prod[2] = ACC_W'(in_int2_2);
                prod[3] = ACC_W'(in_int2_3);
            end
            default: prod[0] = ACC_W'(in_result);
        endcase
    end

    // A group's first beat adds onto zero, so load and accumulate share one adder.
    always_comb begin
        ovf_nxt = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            base[k] = (state == S_IDLE) ? '0 : acc[k];
            sum[k]  = {1'b0, base[k]} + {1'b0, prod[k]};
            if (sum[k][ACC_W]) begin
                acc_nxt[k] = '1;
                ovf_nxt[k] = 1'b1;
            end else begin
                acc_nxt[k] = sum[k][ACC_W-1:0];
                ovf_nxt[k] = (state == S_IDLE) ? 1'b0 : ovf[k];
            end
        end
    end

    always_comb begin
        if (state == S_IDLE) begin
            count_nxt = CNT_W'(1);
        end else if (count == '1) begin
            count_nxt = count;
        end else begin
            count_nxt = count + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= S_IDLE;
            ovf       <= '0;
            mode_q    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
                acc[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        ovf   <= ovf_nxt;
                        count <= count_nxt;
                        for (int unsigned k = 0; k < 4; k++) begin
                            acc[k] <= acc_nxt[k];
                        end
                        if (state == S_IDLE) begin
                            mode_q <= in_mode;
                        end
                        if (in_last) begin
                            state     <= S_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    if (handover) begin
                        state     <= S_IDLE;
                        ovf       <= '0;
                        mode_q    <= '0;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        for (int unsigned k = 0; k < 4; k++) begin
                            acc[k] <= '0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign out_acc[g*ACC_W +: ACC_W] = acc[g];
    end

    assign out_mode  = mode_q;
    assign out_ovf   = ovf;
    assign out_count = count;

endmodule
